// File: rtl/hd44780_text_scheduler.sv
// Text frame buffer and refresh sequencer for the 8-bit HD44780 driver.
// Two clients write through a round-robin arbiter; the driver fetches by address.
module hd44780_text_scheduler #(
    parameter int DEPTH       = 32,
    parameter int REFRESH_MIN = 1000,
    parameter int START_TMO   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    input  logic       clr,
    input  logic       drv_busy,
    output logic       drv_trg,
    input  logic [7:0] drv_idataaddr,
    output logic [7:0] drv_idata,
    output logic       dirty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (REFRESH_MIN > 0) ? $clog2(REFRESH_MIN + 1) : 1;
    localparam int TW = (START_TMO > 1) ? $clog2(START_TMO) : 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT_START,
        S_REFRESH,
        S_HOLDOFF
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cidx_q, cidx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          dirty_q, dirty_d;
    logic          pend_q, pend_d;
    logic          last_q, last_d;
    logic [7:0]    mem_q [DEPTH];

    logic          wr_en;
    logic          clr_we;
    logic          gnt0;
    logic          gnt1;
    logic          wr_hit;
    logic [7:0]    wr_addr;
    logic [7:0]    wr_char;

    always_comb begin
        state_d = state_q;
        cidx_d  = cidx_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        dirty_d = dirty_q;
        pend_d  = pend_q;
        last_d  = last_q;
        wr_en   = 1'b0;
        clr_we  = 1'b0;
        drv_trg = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                cidx_d = cidx_q + AW'(1);
                if (cidx_q == AW'(DEPTH - 1)) begin
                    cidx_d  = '0;
                    dirty_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr || pend_q) begin
                    pend_d  = 1'b0;
                    cidx_d  = '0;
                    state_d = S_CLEAR;
                end else if (dirty_q && hold_q == '0 && !drv_busy) begin
                    drv_trg = 1'b1;
                    dirty_d = 1'b0;
                    tmo_d   = '0;
                    state_d = S_WAIT_START;
                end else begin
                    wr_en = 1'b1;
                end
            end
            S_WAIT_START: begin
                if (clr) pend_d = 1'b1;
                if (drv_busy) begin
                    state_d = S_REFRESH;
                end else if (tmo_q == TW'(START_TMO - 1)) begin
                    dirty_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_REFRESH: begin
                if (clr) pend_d = 1'b1;
                if (!drv_busy) begin
                    hold_d  = HW'(REFRESH_MIN);
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                wr_en = 1'b1;
                if (clr) pend_d = 1'b1;
                // Leave on the cycle the count reaches zero; never wraps.
                if (hold_q <= HW'(1)) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_CLEAR;
        endcase

        // last_q=1 means client 1 was served last, so client 0 wins a tie.
        gnt0    = wr_en && req0_valid && (!req1_valid || last_q);
        gnt1    = wr_en && req1_valid && (!req0_valid || !last_q);
        wr_addr = gnt1 ? req1_addr : req0_addr;
        wr_char = gnt1 ? req1_char : req0_char;
        wr_hit  = (gnt0 || gnt1) && ({1'b0, wr_addr} < 9'(DEPTH));
        if (gnt0 || gnt1) last_d = gnt1;
        if (wr_hit) dirty_d = 1'b1;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign dirty      = dirty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cidx_q  <= '0;
            hold_q  <= '0;
            tmo_q   <= '0;
            dirty_q <= 1'b0;
            pend_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cidx_q  <= cidx_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            dirty_q <= dirty_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[cidx_q] <= 8'h20;
            end else if (wr_hit) begin
                mem_q[wr_addr[AW-1:0]] <= wr_char;
            end
        end
    end

    assign drv_idata = ({1'b0, drv_idataaddr} < 9'(DEPTH))
                     ? mem_q[drv_idataaddr[AW-1:0]] : 8'h20;

endmodule

// File: tb/tb_hd44780_text_scheduler.sv
// Directed bench for hd44780_text_scheduler: write scoreboard plus shadow
// buffer, with the driver handshake played inline by the stimulus sequence.
module tb_hd44780_text_scheduler;

    localparam int DEPTH = 32;
    localparam int RMIN  = 1000;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_addr, req1_addr;
    logic [7:0] req0_char, req1_char;
    logic       req0_ready, req1_ready;
    logic       clr;
    logic       drv_busy;
    logic       drv_trg;
    logic [7:0] drv_idataaddr;
    logic [7:0] drv_idata;
    logic       dirty;

    typedef struct packed {
        logic       c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] shadow [DEPTH];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         fall = 0;
    int         gap = 0;
    int         i0, i1;
    logic       g0, g1;

    hd44780_text_scheduler #(
        .DEPTH(DEPTH),
        .REFRESH_MIN(RMIN),
        .START_TMO(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_addr(req0_addr),
        .req0_char(req0_char),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr(req1_addr),
        .req1_char(req1_char),
        .req1_ready(req1_ready),
        .clr(clr),
        .drv_busy(drv_busy),
        .drv_trg(drv_trg),
        .drv_idataaddr(drv_idataaddr),
        .drv_idata(drv_idata),
        .dirty(dirty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d",
                   tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic c, input logic [7:0] a,
                        input logic [7:0] d);
        wr_t e;
        e.c = c;
        e.a = a;
        e.d = d;
        sb.push_back(e);
        if (a < DEPTH) shadow[int'(a)] = d;
    endtask

    task automatic accept(input logic c, input logic [7:0] a,
                          input logic [7:0] d);
        wr_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_mis++;
            $error("FAIL sb_unexpected: observed write c%0d a%0h d%0h, expected none",
                   c, a, d);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_write", {15'd0, c, a, d}, {15'd0, e});
        end
    endtask

    task automatic observe();
        if (req0_valid && req0_ready) accept(1'b0, req0_addr, req0_char);
        if (req1_valid && req1_ready) accept(1'b1, req1_addr, req1_char);
    endtask

    task automatic tick();
        #1;
        observe();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic wait_trg(input int max);
        int n = 0;
        #1;
        while (drv_trg !== 1'b1 && n < max) begin
            tick();
            #1;
            n++;
        end
        chk("trg_arrives", drv_trg, 1'b1);
        gap = cyc - fall;
    endtask

    // Entered in the trigger cycle; returns in the first HOLDOFF cycle.
    task automatic do_refresh(input int busy_len);
        req0_valid = 1'b1;
        req0_addr  = 8'd9;
        req0_char  = 8'h5a;
        req1_valid = 1'b0;
        #1;
        chk("trg_pulse", drv_trg, 1'b1);
        chk("trg_blocks_wr", req0_ready, 1'b0);
        tick();
        #1;
        chk("ws_dirty", dirty, 1'b0);
        chk("ws_trg", drv_trg, 1'b0);
        chk("ws_rdy0", req0_ready, 1'b0);
        tick();
        drv_busy = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
            if (i < DEPTH) begin
                drv_idataaddr = 8'(i);
                #1;
                chk("refresh_read", drv_idata, shadow[i]);
            end
            tick();
        end
        drv_busy   = 1'b0;
        req0_valid = 1'b0;
        fall       = cyc;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        drv_busy = 1'b0;
        drv_idataaddr = 8'd0;
        req0_valid = 1'b0; req0_addr = 8'd0; req0_char = 8'd0;
        req1_valid = 1'b0; req1_addr = 8'd0; req1_char = 8'd0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 8'h20;

        tick();
        req0_valid = 1'b1; req0_addr = 8'd5; req0_char = 8'h41;
        req1_valid = 1'b1; req1_addr = 8'd6; req1_char = 8'h42;
        #1;
        chk("rst_dirty", dirty, 1'b0);
        chk("rst_trg", drv_trg, 1'b0);
        chk("rst_rdy0", req0_ready, 1'b0);
        chk("rst_rdy1", req1_ready, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("clr_rdy0", req0_ready, 1'b0);
            chk("clr_rdy1", req1_ready, 1'b0);
            chk("clr_trg", drv_trg, 1'b0);
            tick();
        end
        req1_valid = 1'b0;
        #1;
        chk("first_trg", drv_trg, 1'b1);
        chk("first_dirty", dirty, 1'b1);
        do_refresh(100);

        push(1'b0, 8'd3, 8'h48);
        req0_valid = 1'b1; req0_addr = 8'd3; req0_char = 8'h48;
        #1;
        chk("ho_rdy0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        drv_idataaddr = 8'd3;
        #1;
        chk("h_read", drv_idata, 8'h48);
        chk("h_dirty", dirty, 1'b1);
        wait_trg(RMIN + 100);
        chk("spacing1", (gap >= RMIN + 1), 1'b1);

        do_refresh(100);
        push(1'b1, 8'd40, 8'h51);
        req1_valid = 1'b1; req1_addr = 8'd40; req1_char = 8'h51;
        #1;
        chk("oob_rdy1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        drv_idataaddr = 8'd40;
        #1;
        chk("oob_read", drv_idata, 8'h20);
        chk("oob_dirty", dirty, 1'b0);

        push(1'b0, 8'd10, 8'h61);
        push(1'b1, 8'd20, 8'h71);
        push(1'b0, 8'd11, 8'h62);
        push(1'b1, 8'd21, 8'h72);
        push(1'b0, 8'd12, 8'h63);
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 20 && (i0 < 3 || i1 < 2); k++) begin
            req0_valid = (i0 < 3);
            req0_addr  = 8'(10 + i0);
            req0_char  = 8'(8'h61 + i0);
            req1_valid = (i1 < 2);
            req1_addr  = 8'(20 + i1);
            req1_char  = 8'(8'h71 + i1);
            #1;
            g0 = req0_valid & req0_ready;
            g1 = req1_valid & req1_ready;
            tick();
            i0 += int'(g0);
            i1 += int'(g1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("burst_count", i0 + i1, 5);
        chk("burst_dirty", dirty, 1'b1);
        chk("burst_sb_drained", sb.size(), 0);
        wait_trg(RMIN + 100);
        chk("spacing2", (gap >= RMIN + 1), 1'b1);

        for (int i = 1; i <= TMO; i++) begin
            tick();
            #1;
            chk("tmo_trg_lo", drv_trg, 1'b0);
            chk("tmo_dirty_lo", dirty, 1'b0);
        end
        tick();
        #1;
        chk("retrig", drv_trg, 1'b1);
        chk("retrig_dirty", dirty, 1'b1);
        do_refresh(40);

        clr = 1'b1;
        #1;
        tick();
        clr = 1'b0;
        while (cyc < fall + RMIN + 1) tick();
        req0_valid = 1'b1; req0_addr = 8'd3; req0_char = 8'h11;
        #1;
        chk("clrp_rdy0", req0_ready, 1'b0);
        chk("clrp_trg", drv_trg, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            #1;
            chk("clr2_rdy0", req0_ready, 1'b0);
        end
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 8'h20;
        #1;
        chk("clr2_trg", drv_trg, 1'b1);
        chk("clr2_dirty", dirty, 1'b1);

        tick();
        tick();
        drv_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 8'd3; req0_char = 8'h11;
        #1;
        tick();
        #1;
        chk("rr_trg", drv_trg, 1'b0);
        chk("rr_dirty", dirty, 1'b0);
        chk("rr_rdy0", req0_ready, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("rr_clr_rdy0", req0_ready, 1'b0);
            chk("rr_clr_trg", drv_trg, 1'b0);
            tick();
        end
        push(1'b0, 8'd200, 8'h77);
        req0_addr = 8'd200;
        req0_char = 8'h77;
        #1;
        chk("busy_hold_trg", drv_trg, 1'b0);
        chk("rr_dirty_hi", dirty, 1'b1);
        chk("rr_idle_rdy0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        drv_busy = 1'b0;
        #1;
        chk("busy_release_trg", drv_trg, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            drv_idataaddr = 8'(i);
            #1;
            chk("final_read", drv_idata, shadow[i]);
        end
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
